// File: rtl/io_input_reg_if.sv
// CPU-side read bus of the memory-mapped input port block: address, read strobe,
// read data and the change interrupt.
interface io_input_reg_if;
  logic [31:0] addr;
  logic        read_io_enable;
  logic [31:0] dataout;
  logic        io_irq;

  modport master (
    output addr,
    output read_io_enable,
    input  dataout,
    input  io_irq
  );

  modport slave (
    input  addr,
    input  read_io_enable,
    output dataout,
    output io_irq
  );
endinterface

// File: rtl/io_input_reg.sv
// Four synchronised, debounced 32-bit input ports readable through the CPU I/O window,
// with clear-on-read sticky change flags whose OR raises io_irq.
module io_input_reg #(
  parameter int DB_CYCLES = 4
) (
  input  logic           io_clk,
  input  logic           clrn,
  io_input_reg_if.slave  bus,
  input  logic [31:0]    in_port0,
  input  logic [31:0]    in_port1,
  input  logic [31:0]    in_port2,
  input  logic [31:0]    in_port3
);

  localparam logic [15:0] DB_CNT      = 16'(DB_CYCLES);
  localparam logic [5:0]  ADDR_PORT0  = 6'b110000;
  localparam logic [5:0]  ADDR_PORT1  = 6'b110001;
  localparam logic [5:0]  ADDR_PORT2  = 6'b110010;
  localparam logic [5:0]  ADDR_PORT3  = 6'b110011;
  localparam logic [5:0]  ADDR_STATUS = 6'b110100;

  logic [31:0] pin    [4];
  logic [31:0] s1     [4];
  logic [31:0] s2     [4];
  logic [31:0] cand   [4];
  logic [31:0] stable [4];
  logic [15:0] cnt    [4];
  logic [3:0]  chg;
  logic [3:0]  chg_set;
  logic [31:0] rd_data;
  logic        status_rd;
  logic        unused_addr_bits;

  assign pin[0] = in_port0;
  assign pin[1] = in_port1;
  assign pin[2] = in_port2;
  assign pin[3] = in_port3;

  // Only addr[7:2] selects a register; the rest is ignored by design.
  assign unused_addr_bits = ^{bus.addr[31:8], bus.addr[1:0]};

  // A port commits when its synchronised value has matched a non-stable candidate
  // for the full debounce window.
  always_comb begin
    chg_set = '0;
    for (int i = 0; i < 4; i++) begin
      chg_set[i] = (s2[i] != stable[i]) && (s2[i] == cand[i]) && (cnt[i] == DB_CNT);
    end
  end

  // NOTE: the register arrays are small flop banks, not RAM, so they take the async reset
  // like any other state; this is also what lets a reset abandon a pending candidate.
  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < 4; i++) begin
        s1[i]     <= '0;
        s2[i]     <= '0;
        cand[i]   <= '0;
        stable[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values; s2 must see
      // the old s1, and the debounce must see the old s2, within the same edge.
      for (int i = 0; i < 4; i++) begin
        s1[i] <= pin[i];
        s2[i] <= s1[i];
        if (s2[i] == stable[i]) begin
          cnt[i]  <= '0;
          cand[i] <= stable[i];
        end else if (s2[i] != cand[i]) begin
          cand[i] <= s2[i];
          cnt[i]  <= 16'd1;
        end else if (chg_set[i]) begin
          stable[i] <= cand[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  assign status_rd = bus.read_io_enable && (bus.addr[7:2] == ADDR_STATUS);

  // Flags cleared by a status read are exactly those the CPU saw; a commit on the
  // same edge still wins so no event is lost.
  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      chg <= '0;
    end else if (status_rd) begin
      chg <= (chg & ~rd_data[3:0]) | chg_set;
    end else begin
      chg <= chg | chg_set;
    end
  end

  // NOTE: rd_data gets its default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    rd_data = '0;
    unique case (bus.addr[7:2])
      ADDR_PORT0:  rd_data = stable[0];
      ADDR_PORT1:  rd_data = stable[1];
      ADDR_PORT2:  rd_data = stable[2];
      ADDR_PORT3:  rd_data = stable[3];
      ADDR_STATUS: rd_data = {28'b0, chg};
      default:     rd_data = '0;
    endcase
  end

  assign bus.dataout = rd_data;
  assign bus.io_irq  = |chg;

endmodule

// File: tb/tb_io_input_reg.sv
// Self-checking bench for io_input_reg: directed corner sequences, a decode table,
// and random pin activity compared against a run-length reference model.
module tb_io_input_reg;

  localparam int DB = 4;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic [31:0] exp_data;
    logic        exp_irq;
  } vec_t;

  logic        io_clk = 1'b0;
  logic        clrn;
  logic [31:0] pins [4];

  io_input_reg_if bus ();

  io_input_reg #(.DB_CYCLES(DB)) dut (
    .io_clk   (io_clk),
    .clrn     (clrn),
    .bus      (bus),
    .in_port0 (pins[0]),
    .in_port1 (pins[1]),
    .in_port2 (pins[2]),
    .in_port3 (pins[3])
  );

  always #5 io_clk = ~io_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: two-deep pin history, then a value is accepted once the
  // synchronised stream has shown it unbroken for DB+1 edges while it differs
  // from the accepted value.
  logic [31:0] m_s1     [4];
  logic [31:0] m_s2     [4];
  logic [31:0] m_stable [4];
  logic [31:0] run_val  [4];
  int          run_len  [4];
  logic [3:0]  m_chg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    case (a[7:2])
      6'h30:   return m_stable[0];
      6'h31:   return m_stable[1];
      6'h32:   return m_stable[2];
      6'h33:   return m_stable[3];
      6'h34:   return {28'b0, m_chg};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      m_s1[p]     = '0;
      m_s2[p]     = '0;
      m_stable[p] = '0;
      run_val[p]  = '0;
      run_len[p]  = 0;
    end
    m_chg = '0;
  endtask

  // One rising edge: advance the model with the inputs the DUT sampled, then compare.
  task automatic tick();
    logic [3:0]  set;
    logic [31:0] x;
    @(posedge io_clk);
    if (!clrn) begin
      model_reset();
    end else begin
      set = '0;
      for (int p = 0; p < 4; p++) begin
        x = m_s2[p];
        if (x == run_val[p]) run_len[p]++;
        else begin
          run_val[p] = x;
          run_len[p] = 1;
        end
        if (x != m_stable[p] && run_len[p] == DB + 1) begin
          m_stable[p] = x;
          set[p] = 1'b1;
        end
      end
      if (bus.read_io_enable && bus.addr[7:2] == 6'h34) m_chg = set;
      else m_chg = m_chg | set;
      for (int p = 0; p < 4; p++) begin
        m_s2[p] = m_s1[p];
        m_s1[p] = pins[p];
      end
    end
    #1;
    check("model_data", bus.dataout, mdl_read(bus.addr));
    check("model_irq", {31'b0, bus.io_irq}, {31'b0, |m_chg});
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(name, bus.dataout, exp);
  endtask

  task automatic clear_flags();
    bus.addr = 32'hD0;
    bus.read_io_enable = 1'b1;
    tick();
    bus.read_io_enable = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{32'hC0,       1'b0, 32'h1111_1111, 1'b1});
    vecs.push_back('{32'hC4,       1'b1, 32'h2222_2222, 1'b1});
    vecs.push_back('{32'hC8,       1'b0, 32'h3333_3333, 1'b1});
    vecs.push_back('{32'hCC,       1'b1, 32'h4444_4444, 1'b1});
    vecs.push_back('{32'hC0,       1'b1, 32'h1111_1111, 1'b1});
    vecs.push_back('{32'hD8,       1'b1, 32'h0,         1'b1});
    vecs.push_back('{32'h80,       1'b1, 32'h0,         1'b1});
    vecs.push_back('{32'hC3,       1'b0, 32'h1111_1111, 1'b1});
    vecs.push_back('{32'h1D0,      1'b0, 32'hF,         1'b1});
    vecs.push_back('{32'hD0,       1'b1, 32'hF,         1'b0});
    vecs.push_back('{32'hD0,       1'b0, 32'h0,         1'b0});
    vecs.push_back('{32'hFFFF_FFC4, 1'b1, 32'h2222_2222, 1'b0});

    clrn = 1'b0;
    for (int p = 0; p < 4; p++) pins[p] = '0;
    bus.addr = 32'hC0;
    bus.read_io_enable = 1'b0;
    model_reset();

    // Reset with port0 already high: nothing visible until commit on edge 7.
    pins[0] = 32'hFFFF_FFFF;
    repeat (3) @(posedge io_clk);
    #1;
    check("rst_data", bus.dataout, 32'h0);
    check("rst_irq", {31'b0, bus.io_irq}, 32'h0);
    clrn = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 7) begin
        check("rst_port0_hold", bus.dataout, 32'h0);
        check("rst_irq_hold", {31'b0, bus.io_irq}, 32'h0);
      end
    end
    check("rst_port0_commit", bus.dataout, 32'hFFFF_FFFF);
    check("rst_irq_commit", {31'b0, bus.io_irq}, 32'h1);
    read_chk("rst_status", 32'hD0, 32'h1);
    clear_flags();
    check("clear_irq", {31'b0, bus.io_irq}, 32'h0);

    // Clean change on port2.
    pins[2] = 32'h0000_00A5;
    bus.addr = 32'hC8;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 7) check("clean_hold", bus.dataout, 32'h0);
    end
    check("clean_commit", bus.dataout, 32'h0000_00A5);
    read_chk("clean_status", 32'hD0, 32'h4);
    clear_flags();

    // Glitch on port1: 3 cycles filtered, then a 5-cycle pulse commits (and its
    // trailing return to 0 commits again).
    bus.addr = 32'hC4;
    pins[1] = 32'h1;
    repeat (3) tick();
    pins[1] = 32'h0;
    for (int e = 0; e < 10; e++) begin
      tick();
      check("glitch_port1", bus.dataout, 32'h0);
      check("glitch_irq", {31'b0, bus.io_irq}, 32'h0);
    end
    pins[1] = 32'h1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 5) pins[1] = 32'h0;
      if (e == 6) check("pulse5_pre", bus.dataout, 32'h0);
      if (e == 7) begin
        check("pulse5_commit", bus.dataout, 32'h1);
        check("pulse5_irq", {31'b0, bus.io_irq}, 32'h1);
      end
      if (e == 11) check("pulse5_still1", bus.dataout, 32'h1);
    end
    check("pulse5_back0", bus.dataout, 32'h0);
    read_chk("pulse5_status", 32'hD0, 32'h2);
    clear_flags();

    // Restart on port3: a 2-cycle candidate is replaced by a held value.
    bus.addr = 32'hCC;
    pins[3] = 32'h1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == 2) pins[3] = 32'h2;
      if (e < 9) check("restart_hold", bus.dataout, 32'h0);
    end
    check("restart_commit", bus.dataout, 32'h2);
    read_chk("restart_status", 32'hD0, 32'h8);
    clear_flags();

    // Read-clear race: port1 commits on the edge of a status read that clears port0's flag.
    pins[0] = 32'h0000_1234;
    repeat (7) tick();
    read_chk("race_pre_status", 32'hD0, 32'h1);
    pins[1] = 32'h0000_0055;
    repeat (6) tick();
    bus.read_io_enable = 1'b1;
    read_chk("race_read_val", 32'hD0, 32'h1);
    tick();
    check("race_status", bus.dataout, 32'h2);
    check("race_irq", {31'b0, bus.io_irq}, 32'h1);
    tick();
    bus.read_io_enable = 1'b0;
    check("race_second_clear", bus.dataout, 32'h0);
    check("race_irq_low", {31'b0, bus.io_irq}, 32'h0);

    // Asynchronous reset mid-count; every port's pending value recommits on the same edge.
    pins[2] = 32'h0000_CAFE;
    bus.addr = 32'hC8;
    repeat (3) tick();
    #2;
    clrn = 1'b0;
    model_reset();
    read_chk("arst_port2", 32'hC8, 32'h0);
    read_chk("arst_port0", 32'hC0, 32'h0);
    read_chk("arst_status", 32'hD0, 32'h0);
    check("arst_irq", {31'b0, bus.io_irq}, 32'h0);
    clrn = 1'b1;
    bus.addr = 32'hC8;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 7) check("arst_hold", bus.dataout, 32'h0);
    end
    check("arst_recommit", bus.dataout, 32'h0000_CAFE);
    read_chk("arst_status_all", 32'hD0, 32'hF);

    // Decode table on known port contents.
    pins[0] = 32'h1111_1111;
    pins[1] = 32'h2222_2222;
    pins[2] = 32'h3333_3333;
    pins[3] = 32'h4444_4444;
    repeat (7) tick();
    foreach (vecs[i]) begin
      bus.read_io_enable = vecs[i].rd;
      read_chk($sformatf("table%0d_data", i), vecs[i].addr, vecs[i].exp_data);
      tick();
      check($sformatf("table%0d_irq", i), {31'b0, bus.io_irq}, {31'b0, vecs[i].exp_irq});
    end
    bus.read_io_enable = 1'b0;

    // Random pin activity with random reads, checked against the model every edge.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 3))
            0:       pins[p] = 32'h0;
            1:       pins[p] = 32'hA5A5_0001;
            2:       pins[p] = 32'hFFFF_FFFF;
            default: pins[p] = $urandom;
          endcase
        end
      end
      case ($urandom_range(0, 7))
        0:       bus.addr = 32'hC0;
        1:       bus.addr = 32'hC4;
        2:       bus.addr = 32'hC8;
        3:       bus.addr = 32'hCC;
        4, 5:    bus.addr = 32'hD0;
        6:       bus.addr = 32'hD4;
        default: bus.addr = $urandom;
      endcase
      bus.read_io_enable = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
